// File: rtl/alu_seq_pkg.sv
// Shared widths and the command record that flows from the issue FIFO to the ALU.
package alu_seq_pkg;
    localparam int DATA_W = 8;
    localparam int OP_W   = 3;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OP_W-1:0]   op;
    } alu_cmd_t;
endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; push is ignored when full and pop when empty, with no bypass paths.
module alu_cmd_fifo
    import alu_seq_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  alu_cmd_t      i_data,
    input  logic          i_pop,
    output alu_cmd_t      o_head,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);
    alu_cmd_t      r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Storage carries no reset; occupancy and pointers alone define validity.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the combinational ALU: FIFO -> registered operands/enable -> result register.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [OP_W-1:0]   cmd_op,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [OP_W-1:0]   operation,
    output logic              en,
    input  logic [DATA_W-1:0] alu_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [OP_W-1:0]   res_op,
    output logic [CW-1:0]     fifo_count
);
    alu_cmd_t          w_head;
    alu_cmd_t          w_cmd;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_capture;
    logic              w_issue;
    alu_cmd_t          r_iss;
    logic              r_en;
    logic              r_res_valid;
    logic [DATA_W-1:0] r_res_data;
    logic [OP_W-1:0]   r_res_op;

    assign w_cmd     = '{a: cmd_a, b: cmd_b, op: cmd_op};
    assign cmd_ready = !w_full;
    assign w_push    = cmd_valid && cmd_ready;
    assign w_capture = r_en && (!r_res_valid || res_ready);
    // The ALU slot frees up either because it is idle or because its result leaves this edge.
    assign w_issue   = !w_empty && (!r_en || w_capture);

    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_cmd),
        .i_pop   (w_issue),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iss <= '0;
            r_en  <= 1'b0;
        end else if (w_issue) begin
            r_iss <= w_head;
            r_en  <= 1'b1;
        end else if (w_capture) begin
            r_en  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_op    <= '0;
        end else if (w_capture) begin
            r_res_valid <= 1'b1;
            r_res_data  <= alu_out;
            r_res_op    <= r_iss.op;
        end else if (r_res_valid && res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    assign A         = r_iss.a;
    assign B         = r_iss.b;
    assign operation = r_iss.op;
    assign en        = r_en;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_op    = r_res_op;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench: a behavioural ALU closes the loop; expected results come from hand values or the ALU model.
module tb_alu_cmd_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_a = '0;
    logic [7:0] cmd_b = '0;
    logic [2:0] cmd_op = '0;
    logic [7:0] A, B;
    logic [2:0] operation;
    logic       en;
    logic [7:0] alu_out;
    logic       res_valid;
    logic       res_ready = 1'b1;
    logic [7:0] res_data;
    logic [2:0] res_op;
    logic [2:0] fifo_count;

    int errors = 0;
    int checks = 0;
    int got, k, stale;
    logic will_push;

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ~a;
            3'd6: return a << 1;
            default: return a >> 1;
        endcase
    endfunction

    assign alu_out = en ? alu_f(A, B, operation) : 8'h00;

    alu_cmd_sequencer #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .A(A), .B(B),
        .operation(operation), .en(en), .alu_out(alu_out), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_op(res_op), .fifo_count(fifo_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        cmd_valid = 1'b1;
        cmd_a = a;
        cmd_b = b;
        cmd_op = op;
    endtask

    // Commands used by the backpressure and wrap tests.
    function automatic logic [7:0] ca(input int i); return 8'(i * 10 + 1); endfunction
    function automatic logic [7:0] cb(input int i); return 8'(i + 2); endfunction
    function automatic logic [7:0] wa(input int i); return 8'(i * 7 + 3); endfunction
    function automatic logic [7:0] wb(input int i); return 8'(i + 1); endfunction

    task automatic chk_reset(input string pfx);
        chk({pfx, "_A"}, A, 0);
        chk({pfx, "_B"}, B, 0);
        chk({pfx, "_op"}, operation, 0);
        chk({pfx, "_en"}, en, 0);
        chk({pfx, "_rv"}, res_valid, 0);
        chk({pfx, "_rd"}, res_data, 0);
        chk({pfx, "_rop"}, res_op, 0);
        chk({pfx, "_cnt"}, fifo_count, 0);
        chk({pfx, "_crdy"}, cmd_ready, 1);
    endtask

    initial begin
        #1;
        chk_reset("rst");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single command latency
        drive(8'd12, 8'd23, 3'b000);
        step();
        cmd_valid = 1'b0;
        chk("s_cnt_e0", fifo_count, 1);
        chk("s_en_e0", en, 0);
        step();
        chk("s_en_e1", en, 1);
        chk("s_A_e1", A, 12);
        chk("s_B_e1", B, 23);
        chk("s_op_e1", operation, 0);
        chk("s_rv_e1", res_valid, 0);
        step();
        chk("s_rv_e2", res_valid, 1);
        chk("s_rd_e2", res_data, 35);
        chk("s_rop_e2", res_op, 0);
        chk("s_en_e2", en, 0);
        chk("s_Ahold", A, 12);
        chk("s_Bhold", B, 23);
        step();
        chk("s_rv_e3", res_valid, 0);

        // Back-to-back throughput
        drive(8'd12, 8'd23, 3'b000); step();
        drive(8'd34, 8'd23, 3'b001); step();
        drive(8'd12, 8'd23, 3'b011); step();
        cmd_valid = 1'b0;
        chk("b_rv0", res_valid, 1); chk("b_rd0", res_data, 35); chk("b_rop0", res_op, 0);
        step();
        chk("b_rv1", res_valid, 1); chk("b_rd1", res_data, 11); chk("b_rop1", res_op, 1);
        step();
        chk("b_rv2", res_valid, 1); chk("b_rd2", res_data, 31); chk("b_rop2", res_op, 3);
        step();
        chk("b_rv3", res_valid, 0);

        // Backpressure fills every storage slot
        res_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(ca(i), cb(i), 3'(i));
            chk("f_rdy", cmd_ready, 1);
            step();
        end
        drive(ca(6), cb(6), 3'(6));
        chk("f_full_rdy", cmd_ready, 0);
        chk("f_full_cnt", fifo_count, 4);
        step();
        chk("f_rdy7", cmd_ready, 0);
        chk("f_cnt7", fifo_count, 4);
        chk("f_en", en, 1);
        chk("f_A", A, ca(1));
        chk("f_B", B, cb(1));
        chk("f_rv", res_valid, 1);
        chk("f_rd", res_data, alu_f(ca(0), cb(0), 3'd0));
        step();
        chk("f_Astable", A, ca(1));
        chk("f_rdstable", res_data, alu_f(ca(0), cb(0), 3'd0));

        // One-cycle release: result advances and next head issues on the same edge
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("r_rd", res_data, alu_f(ca(1), cb(1), 3'd1));
        chk("r_rop", res_op, 1);
        chk("r_en", en, 1);
        chk("r_A", A, ca(2));
        chk("r_cnt", fifo_count, 3);

        // Drain; c6 is accepted once space opens
        res_ready = 1'b1;
        got = 1;
        for (int cyc = 0; cyc < 40 && got < 7; cyc++) begin
            if (res_valid) begin
                chk("d_rd", res_data, alu_f(ca(got), cb(got), 3'(got)));
                chk("d_rop", res_op, 32'(got));
                got++;
            end
            will_push = cmd_valid && cmd_ready;
            step();
            if (will_push) cmd_valid = 1'b0;
        end
        chk("d_count", got, 7);
        chk("d_cnt0", fifo_count, 0);
        chk("d_accepted", cmd_valid, 0);

        // Wrap-around with continuous push/issue
        k = 0;
        got = 0;
        for (int cyc = 0; cyc < 30 && got < 10; cyc++) begin
            if (res_valid) begin
                chk("w_rd", res_data, alu_f(wa(got), wb(got), 3'(got)));
                got++;
            end
            chk("w_cnt_le1", (fifo_count <= 1), 1);
            if (k < 10) drive(wa(k), wb(k), 3'(k));
            else cmd_valid = 1'b0;
            will_push = cmd_valid && cmd_ready;
            step();
            if (will_push) k++;
        end
        cmd_valid = 1'b0;
        chk("w_count", got, 10);

        // Asynchronous reset mid-operation
        step();
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(wa(i), wb(i), 3'(i));
            step();
        end
        chk("m_cnt", fifo_count, 3);
        chk("m_en", en, 1);
        #3 rst_n = 1'b0;
        cmd_valid = 1'b0;
        #1;
        chk_reset("arst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        res_ready = 1'b1;
        stale = 0;
        repeat (6) begin
            step();
            if (res_valid || en) stale++;
        end
        chk("m_stale", stale, 0);
        chk("m_cnt_post", fifo_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Upstream issue stage for the team's 8-bit combinational ALU (ports A, B, operation, en, alu_out). It accepts operand/opcode commands over a valid/ready handshake and buffers them in a small FIFO. It drives the ALU with registered operands and enable, then captures alu_out into a result register presented downstream with valid/ready backpressure. Sustained throughput is one command per cycle when the result consumer is not stalling.

Parameters:
DATA_W, 8, operand and result width
OP_W, 3, opcode width
DEPTH, 4, command FIFO entries (power of two, >=2)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept (FIFO not full)
cmd_a  in  DATA_W  operand A
cmd_b  in  DATA_W  operand B
cmd_op  in  OP_W  opcode, passed through to the ALU without decoding
A  out  DATA_W  to ALU operand A
B  out  DATA_W  to ALU operand B
operation  out  OP_W  to ALU opcode
en  out  1  to ALU enable; 1 = operands valid this cycle
alu_out  in  DATA_W  ALU result (combinational from A/B/operation/en)
res_valid  out  1  result register holds a result
res_ready  in  1  downstream accepts the result
res_data  out  DATA_W  captured alu_out
res_op  out  OP_W  opcode that produced res_data
fifo_count  out  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Reset (async assert, synchronous release): A=0, B=0, operation=0, en=0, res_valid=0, res_data=0, res_op=0, fifo_count=0, cmd_ready=1. Reset mid-operation discards all buffered and in-flight commands.
- push = cmd_valid && cmd_ready.
- cmd_ready = (fifo_count != DEPTH).
- When full, no push is accepted even if a pop occurs in the same cycle (no full-bypass).
- No empty-bypass: a command pushed at edge k is poppable at the earliest in the cycle after edge k.
- capture = en && (!res_valid || res_ready).
- issue (pop) = fifo non-empty && (!en || capture).
- On issue: A, B, operation <= FIFO head; en <= 1.
- Else if capture: en <= 0; A, B, operation hold their last values.
- Else (stall): en, A, B, operation hold, so alu_out stays stable.
- On capture: res_data <= alu_out, res_op <= operation, res_valid <= 1.
- Else if res_valid && res_ready: res_valid <= 0.
- Else: the result registers hold.
- Latency: command accepted at edge E0 gives en=1 after E1 and res_valid=1 after E2.
- Back-to-back commands with res_ready=1 produce one result per cycle.
- Ordering is strict FIFO; no command is ever dropped or duplicated.
- Maximum storage is DEPTH+2 commands: DEPTH in the FIFO, 1 held on the ALU, 1 in the result register.
- Simultaneous push and issue with count unchanged: fifo_count stays the same and pointers wrap modulo DEPTH.

Decomposition:
- Package alu_seq_pkg: DATA_W and OP_W localparams; packed struct alu_cmd_t {a, b, op}.
- Sub-module alu_cmd_fifo: synchronous FIFO of alu_cmd_t, DEPTH entries, push/pop/full/empty/count, same clk/rst_n.
- Top level holds the issue register, the result register and the capture/issue logic.

Test Plan:
- Single command: reset, push (12,23,000) at edge E0 -> A=12, B=23, operation=000, en=1 after E1; res_valid=1, res_data equals the ALU model result, res_op=000 after E2; en=0 after E2 with A/B held.
- Back-to-back: push (12,23,000), (34,23,001), (12,23,011) on consecutive cycles with res_ready=1 -> three res_valid cycles in a row, in order, with res_op 000, 001, 011.
- Backpressure and full:
  - Stimulus: res_ready=0, push 7 commands.
  - Expected: first command sits in the result register, second held on en=1 with A/B stable, four in the FIFO.
  - cmd_ready=0 after the 6th push, so the 7th waits; fifo_count=4.
  - Release res_ready -> all six drain in order, the 7th is then accepted, and none are lost.
- Stall release: with en held and res_valid=1, assert res_ready for one cycle -> res_data updates to the held result and the next FIFO head issues on the same edge.
- Wrap-around: 10 push/issue pairs with res_ready=1 -> pointers wrap, fifo_count never exceeds 1, results are in order.
- Reset mid-operation: with the FIFO at count 3 and en=1, pulse rst_n low asynchronously between edges -> all outputs reach their reset values immediately; no stale result appears after release.
